// File: rtl/exp_pipe_arb.sv
// rtl/exp_pipe_arb.sv - N-requester arbiter and tag tracker in front of a shared fixed-latency exp pipeline
// Optional feature macro: EXP_ARB_ROUND_ROBIN_EN (round-robin arbitration; fixed priority when undefined)
module exp_pipe_arb #(
  parameter int N_REQ    = 4,
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32,
  parameter int LATENCY  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTHIN-1:0] req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [WIDTHOUT-1:0]      rsp_y,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic                     pipe_i_valid,
  output logic [WIDTHIN-1:0]       pipe_i_x,
  output logic                     pipe_i_ready,
  input  logic [WIDTHOUT-1:0]      pipe_o_y,
  output logic                     busy,
  output logic                     idle
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]   tag_id [LATENCY];
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic              head_ready;
  logic              xfer;

  // Head-of-pipe decode: which requester owns the result now leaving, and whether it can take it
  always_comb begin
    head_ready = 1'b0;
    rsp_valid  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (tag_id[LATENCY-1] == ID_W'(k)) begin
        rsp_valid[k] = tag_v[LATENCY-1];
        head_ready   = rsp_ready[k];
      end
    end
  end

  // The whole pipeline moves only when the head slot is empty or its owner accepts it
  assign pipe_i_ready = !tag_v[LATENCY-1] | head_ready;
  assign rsp_y        = pipe_o_y;
  assign busy         = |tag_v;
  assign idle         = (state == IDLE);

`ifdef EXP_ARB_ROUND_ROBIN_EN
  // rr_ptr holds the index with highest priority next, i.e. one above the last granted requester
  logic [ID_W-1:0] rr_ptr;

  // Round-robin search starting at rr_ptr and wrapping past N_REQ-1
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!grant_any && req_valid[(int'(rr_ptr) + off) % N_REQ]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'((int'(rr_ptr) + off) % N_REQ);
      end
    end
  end

  // Pointer moves past the winner only when an operand actually enters the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end
`else
  // Fixed priority: lowest asserted index wins
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(k);
      end
    end
  end
`endif

  assign pipe_i_valid = (state == RUN) && grant_any;
  assign xfer         = pipe_i_valid && pipe_i_ready;

  // Operand mux and one-hot accept toward the granted requester
  always_comb begin
    pipe_i_x  = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pipe_i_valid && (grant_id == ID_W'(k))) begin
        pipe_i_x     = req_x[k*WIDTHIN +: WIDTHIN];
        req_ready[k] = pipe_i_ready;
      end
    end
  end

  // Tag shift register tracks owner of each pipeline slot; advances in lockstep with the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else if (pipe_i_ready) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0]  <= xfer;
      tag_id[0] <= xfer ? grant_id : '0;
    end
  end

  // Control FSM: RUN accepts, DRAIN waits for in-flight results before going IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cfg_en) state <= RUN;
        RUN:     if (!cfg_en) state <= DRAIN;
        DRAIN:   if (cfg_en) state <= RUN;
                 else if (!(|tag_v)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_pipe_arb.sv
// tb/tb_exp_pipe_arb.sv - randomized and directed self-checking bench for exp_pipe_arb
module tb_exp_pipe_arb;

  localparam int N  = 4;
  localparam int WI = 16;
  localparam int WO = 32;
  localparam int L  = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*WI-1:0] req_x = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [WO-1:0]   rsp_y;
  logic [N-1:0]    rsp_ready = '1;
  logic            pipe_i_valid;
  logic [WI-1:0]   pipe_i_x;
  logic            pipe_i_ready;
  logic [WO-1:0]   pipe_o_y;
  logic            busy;
  logic            idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exp_pipe_arb #(.N_REQ(N), .WIDTHIN(WI), .WIDTHOUT(WO), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
    .pipe_i_valid(pipe_i_valid), .pipe_i_x(pipe_i_x), .pipe_i_ready(pipe_i_ready),
    .pipe_o_y(pipe_o_y), .busy(busy), .idle(idle)
  );

  // Stand-in for the exp pipeline: exp(0) maps to 1.0 in Q7.25, other operands to a distinct tag value
  function automatic logic [WO-1:0] f(input logic [WI-1:0] x);
    return 32'h0200_0000 + 32'(x) * 32'd3;
  endfunction

  logic [WO-1:0] pstage [L];
  always @(posedge clk) begin
    if (pipe_i_ready) begin
      for (int i = L - 1; i > 0; i--) pstage[i] <= pstage[i-1];
      pstage[0] <= f(pipe_i_x);
    end
  end
  assign pipe_o_y = pstage[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight results as a FIFO, each with its count of pipeline advances
  typedef struct {
    int           id;
    logic [WO-1:0] y;
    int           age;
  } item_t;

  item_t q[$];
  int    m_state = 0;   // 0 idle, 1 run, 2 drain
  int    m_ptr = 0;

  always @(negedge clk) begin
    logic          head;
    logic          e_pir;
    logic [N-1:0]  e_rv;
    logic [N-1:0]  e_rr;
    logic [WI-1:0] e_pix;
    int            g;
    int            nxt;
    if (reset) begin
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_pipe_i_valid", 64'(pipe_i_valid), 64'd0);
      chk("rst_pipe_i_x", 64'(pipe_i_x), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_pipe_i_ready", 64'(pipe_i_ready), 64'd1);
      q.delete();
      m_state = 0;
      m_ptr = 0;
    end else begin
      head  = (q.size() > 0) && (q[0].age == L - 1);
      e_pir = !head || rsp_ready[q[0].id];
      e_rv  = head ? (N'(1) << q[0].id) : '0;
      g = -1;
      if (m_state == 1) begin
        for (int off = 0; off < N; off++) begin
          int k;
          k = (m_ptr + off) % N;
          if (g < 0 && req_valid[k]) g = k;
        end
      end
      e_pix = (g >= 0) ? req_x[g*WI +: WI] : '0;
      e_rr  = (g >= 0 && e_pir) ? (N'(1) << g) : '0;
      chk("pipe_i_ready", 64'(pipe_i_ready), 64'(e_pir));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("pipe_i_valid", 64'(pipe_i_valid), 64'(g >= 0));
      chk("pipe_i_x", 64'(pipe_i_x), 64'(e_pix));
      chk("req_ready", 64'(req_ready), 64'(e_rr));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      chk("idle", 64'(idle), 64'(m_state == 0));
      if (head) chk("rsp_y", 64'(rsp_y), 64'(q[0].y));
      nxt = m_state;
      case (m_state)
        0: if (cfg_en) nxt = 1;
        1: if (!cfg_en) nxt = 2;
        default: if (cfg_en) nxt = 1; else if (q.size() == 0) nxt = 0;
      endcase
      m_state = nxt;
      if (e_pir) begin
        if (head) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (g >= 0) begin
          q.push_back('{g, f(e_pix), 0});
`ifdef EXP_ARB_ROUND_ROBIN_EN
          m_ptr = (g + 1) % N;
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
    cfg_en = 1'b0;
  endtask

  int cnt;

  initial begin
    // Reset values, literal
    step();
    step();
    #2;
    chk("lit_rst_idle", 64'(idle), 64'd1);
    chk("lit_rst_pir", 64'(pipe_i_ready), 64'd1);
    step();
    reset = 1'b0;
    #2;
    chk("lit_post_rst_idle", 64'(idle), 64'd1);
    chk("lit_post_rst_busy", 64'(busy), 64'd0);

    // Single request from requester 2, x = 0
    step();
    cfg_en = 1'b1;
    step();
    req_valid = 4'b0100;
    req_x = '0;
    #2;
    chk("lit_single_req_ready", 64'(req_ready), 64'b0100);
    for (int i = 1; i <= 6; i++) begin
      step();
      req_valid = '0;
      #2;
      chk("lit_single_rsp_valid", 64'(rsp_valid), (i == 6) ? 64'b0100 : 64'd0);
      if (i == 6) chk("lit_single_rsp_y", 64'(rsp_y), 64'h0200_0000);
    end

    // Contention
    do_reset();
    cfg_en = 1'b1;
    step();
    req_x = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
`ifdef EXP_ARB_ROUND_ROBIN_EN
    req_valid = 4'b1111;
`else
    req_valid = 4'b1001;
`endif
    for (int c = 0; c < 5; c++) begin
      #2;
`ifdef EXP_ARB_ROUND_ROBIN_EN
      chk("lit_rr_grant", 64'(req_ready), 64'(1 << (c % 4)));
`else
      chk("lit_fixed_grant", 64'(req_ready), 64'b0001);
`endif
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 10; c++) step();

    // Backpressure on requester 1
    req_valid = 4'b0010;
    req_x = '0;
    req_x[WI +: WI] = 16'h1234;
    #2;
    chk("lit_bp_accept", 64'(req_ready), 64'b0010);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) begin
        req_valid = 4'b0001;
        rsp_ready = 4'b1101;
      end
    end
    for (int s = 0; s < 3; s++) begin
      #2;
      chk("lit_bp_pir", 64'(pipe_i_ready), 64'd0);
      chk("lit_bp_req_ready", 64'(req_ready), 64'd0);
      chk("lit_bp_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("lit_bp_rsp_y", 64'(rsp_y), 64'h0200_369C);
      step();
    end
    rsp_ready = '1;
    #2;
    chk("lit_bp_resume_pir", 64'(pipe_i_ready), 64'd1);
    chk("lit_bp_resume_req", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    for (int c = 0; c < 10; c++) step();

    // Drain with three results in flight
    req_valid = 4'b1000;
    step();
    step();
    step();
    req_valid = '0;
    cfg_en = 1'b0;
    step();
    req_valid = '1;
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      #2;
      chk("lit_drain_no_accept", 64'(req_ready), 64'd0);
      if (rsp_valid != '0) cnt++;
      step();
    end
    chk("lit_drain_count", 64'(cnt), 64'd3);
    #2;
    chk("lit_drain_idle", 64'(idle), 64'd1);
    chk("lit_drain_busy", 64'(busy), 64'd0);
    req_valid = '0;

    // Mid-flight reset with four results in flight
    cfg_en = 1'b1;
    step();
    req_valid = '1;
    req_x = {$urandom, $urandom};
    for (int c = 0; c < 4; c++) step();
    req_valid = '0;
    step();
    #2;
    chk("lit_mid_busy_before", 64'(busy), 64'd1);
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cfg_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #2;
      chk("lit_mid_no_rsp", 64'(rsp_valid), 64'd0);
      step();
    end
    #2;
    chk("lit_mid_idle", 64'(idle), 64'd1);

    // Randomized traffic
    cfg_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      req_valid = N'($urandom);
      req_x = {$urandom, $urandom};
      rsp_ready = N'($urandom | $urandom);
      if ($urandom_range(0, 39) == 0) cfg_en = ~cfg_en;
    end
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    for (int c = 0; c < 20; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_pipe_arb.md
EXP_PIPE_ARB -- requirements
Module: exp_pipe_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one exp pipeline.
REQ-002 SHALL have parameter WIDTHIN, default 16: operand width, Q2.14.
REQ-003 SHALL have parameter WIDTHOUT, default 32: result width, Q7.25.
REQ-004 SHALL have parameter LATENCY, default 6: pipeline depth in enabled cycles from operand sample to result.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cfg_en  in  1  accept new requests when high.
- req_valid  in  N_REQ  per-requester operand valid.
- req_x  in  N_REQ*WIDTHIN  operands; requester i occupies bits [i*WIDTHIN +: WIDTHIN].
- req_ready  out  N_REQ  per-requester operand accept.
- rsp_valid  out  N_REQ  per-requester result valid, one-hot or zero.
- rsp_y  out  WIDTHOUT  shared result bus.
- rsp_ready  in  N_REQ  per-requester result accept.
- pipe_i_valid  out  1  to pipeline i_valid.
- pipe_i_x  out  WIDTHIN  to pipeline i_x.
- pipe_i_ready  out  1  to pipeline i_ready; acts as the global pipeline enable.
- pipe_o_y  in  WIDTHOUT  from pipeline o_y.
- busy  out  1  high while any tag is in flight.
- idle  out  1  high in state IDLE.

Function
REQ-006 SHALL keep a LATENCY-deep tag shift register (valid bit plus requester ID, clog2(N_REQ) bits), advancing only when pipe_i_ready is high.
REQ-007 SHALL drive pipe_i_ready = !tag_v[LATENCY-1] | rsp_ready[tag_id[LATENCY-1]].
REQ-008 SHALL NOT use pipeline o_valid/o_ready; result validity is derived only from the tag register, with no combinational path from pipeline outputs.
REQ-009 SHALL drive rsp_valid[k] = tag_v[LATENCY-1] & (tag_id[LATENCY-1]==k) and rsp_y = pipe_o_y.
REQ-010 SHALL assert pipe_i_valid = 1 only in state RUN when some req_valid is high, granting exactly one requester g.
REQ-011 SHALL assert req_ready[g] in the same cycle that pipe_i_valid and pipe_i_ready are both high, and SHALL assert no other req_ready bit.
REQ-012 SHALL drive pipe_i_x = operand of g when a grant exists, else zero.
REQ-013 SHALL treat a transfer on req_ready[g]&req_valid[g] as loading tag stage 0 with {1,g}, and SHALL load {0,x} otherwise when advancing.
REQ-014 SHALL give a result latency of exactly LATENCY cycles from operand transfer to rsp_valid when no stall occurs; each stall cycle adds one cycle.
REQ-015 SHALL hold the grant, tags and rsp_y stable while pipe_i_ready is low.
REQ-016 SHALL implement a state machine with states IDLE, RUN and DRAIN:
- IDLE to RUN when cfg_en=1.
- RUN to DRAIN when cfg_en=0.
- DRAIN to RUN when cfg_en=1.
- DRAIN to IDLE when all tag_v are zero.
REQ-017 SHALL accept no new operands in IDLE or DRAIN, but SHALL still deliver in-flight results in those states.
REQ-018 SHALL drive busy = OR of tag_v and idle = (state==IDLE).

Reset
REQ-019 SHALL on reset clear all tag_v and the round-robin pointer and enter IDLE, asynchronously.
REQ-020 SHALL drive these values during and immediately after reset: rsp_valid=0, req_ready=0, pipe_i_valid=0, pipe_i_x=0, busy=0, idle=1, pipe_i_ready=1.
REQ-021 SHALL discard results in flight at a mid-operation reset; no rsp_valid is produced for them.

Configuration
REQ-022 SHALL compile round-robin arbitration when EXP_ARB_ROUND_ROBIN_EN is defined: priority starts one above the last granted index and wraps from N_REQ-1 to 0; the pointer updates only on a transfer.
REQ-023 SHALL compile fixed priority when EXP_ARB_ROUND_ROBIN_EN is undefined: the lowest asserted index wins, and the pointer is absent.

Verification
REQ-024 Single request: reset, cfg_en=1, req 2 sends x=0x0000 with rsp_ready all high -> rsp_valid=4'b0100 exactly 6 cycles later, rsp_y=0x0200_0000 (1.0 in Q7.25).
REQ-025 Contention with round-robin: all four requesters hold valid continuously -> grants 0,1,2,3,0 on consecutive cycles, with responses returned in the same order 6 cycles later.
REQ-026 Contention with fixed priority (macro undefined): requesters 0 and 3 hold valid continuously -> requester 0 is granted every cycle and requester 3 is never granted.
REQ-027 Backpressure: rsp_ready[1]=0 while a requester-1 result is at the head -> pipe_i_ready=0, all req_ready=0, and the head result stays stable; raising rsp_ready[1] delivers it and resumes accepting.
REQ-028 Drain: drop cfg_en with 3 results in flight -> no further req_ready; 3 responses are delivered; then idle=1 and busy=0.
REQ-029 Mid-flight reset: assert reset with 4 results in flight -> rsp_valid never asserts for them, and idle=1 after reset.
